// File: rtl/lcd_cell_painter.sv
// Paints one 16x12-grid cell as a solid RGB565 square on an 8080-style 8-bit LCD.
// Sequence: CASET, PASET, RAMWR, then CELL_PX^2 pixels. Each byte takes two clocks (strobe low, then high).
module lcd_cell_painter #(
  parameter int unsigned CELL_PX   = 20,
  parameter logic [15:0] COL_BG    = 16'h0000,
  parameter logic [15:0] COL_HEAD  = 16'h07E0,
  parameter logic [15:0] COL_BODY  = 16'h03E0,
  parameter logic [15:0] COL_APPLE = 16'hF800,
  parameter logic [15:0] COL_BORD  = 16'hFFFF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en_update,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic [7:0] lcd_d,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic       lcd_csx
);

  localparam int unsigned NPIX  = CELL_PX * CELL_PX;
  localparam int unsigned PIX_W = ($clog2(NPIX) > 16) ? $clog2(NPIX) : 16;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [15:0] CELL16  = 16'(CELL_PX);
  localparam logic [15:0] CELL_M1 = 16'(CELL_PX - 1);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PARAM,
    S_PIXEL,
    S_SKIP,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t           state_q;
  logic [3:0]       x_q;
  logic [3:0]       y_q;
  logic [15:0]      colour_q;
  logic [1:0]       grp_q;
  logic [1:0]       pcnt_q;
  logic [PIX_W-1:0] pix_q;
  logic             lo_q;
  logic             phase_q;
  logic             cmd_done_q;
  logic             busy_q;
  logic [7:0]       lcd_d_q;
  logic             dcx_q;
  logic             wrx_q;
  logic             csx_q;

  logic [15:0] x0_d, x1_d, y0_d, y1_d;
  logic [1:0]  pidx_d;
  logic [7:0]  param_d;

  function automatic logic [15:0] colour_of(input logic [2:0] code);
    case (code)
      3'b001:  colour_of = COL_HEAD;
      3'b010:  colour_of = COL_BODY;
      3'b011:  colour_of = COL_APPLE;
      3'b100:  colour_of = COL_BORD;
      default: colour_of = COL_BG;
    endcase
  endfunction

  function automatic logic [7:0] param_byte(input logic [15:0] lo_v, input logic [15:0] hi_v,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    param_byte = lo_v[15:8];
      2'd1:    param_byte = lo_v[7:0];
      2'd2:    param_byte = hi_v[15:8];
      default: param_byte = hi_v[7:0];
    endcase
  endfunction

  // Window corners from the latched cell; 15*CELL_PX+CELL_PX-1 fits in 16 bits for any sane cell size.
  always_comb begin
    x0_d    = 16'(x_q) * CELL16;
    x1_d    = x0_d + CELL_M1;
    y0_d    = 16'(y_q) * CELL16;
    y1_d    = y0_d + CELL_M1;
    pidx_d  = (state_q == S_CMD) ? 2'd0 : pcnt_q + 2'd1;
    param_d = (grp_q == 2'd0) ? param_byte(x0_d, x1_d, pidx_d)
                              : param_byte(y0_d, y1_d, pidx_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      grp_q      <= '0;
      pcnt_q     <= '0;
      pix_q      <= '0;
      lo_q       <= 1'b0;
      phase_q    <= 1'b0;
      cmd_done_q <= 1'b0;
      busy_q     <= 1'b0;
      lcd_d_q    <= 8'h00;
      dcx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      csx_q      <= 1'b1;
    end else begin
      cmd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_update) begin
            x_q      <= x;
            y_q      <= y;
            colour_q <= colour_of(obj_code);
            busy_q   <= 1'b1;
            if (y > 4'd11) begin
              state_q <= S_SKIP;
            end else begin
              state_q <= S_CMD;
              grp_q   <= 2'd0;
              pcnt_q  <= 2'd0;
              phase_q <= 1'b0;
              lcd_d_q <= CMD_CASET;
              dcx_q   <= 1'b0;
              wrx_q   <= 1'b0;
              csx_q   <= 1'b0;
            end
          end
        end

        S_SKIP: begin
          cmd_done_q <= 1'b1;
          state_q    <= S_DONE;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_RELEASE;
        end

        S_RELEASE: begin
          // Level request: only a fresh assertion after a drop starts the next cell.
          if (!en_update) state_q <= S_IDLE;
        end

        default: begin
          if (!phase_q) begin
            wrx_q   <= 1'b1;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            wrx_q   <= 1'b0;
            case (state_q)
              S_CMD: begin
                dcx_q <= 1'b1;
                if (grp_q == 2'd2) begin
                  state_q <= S_PIXEL;
                  pix_q   <= '0;
                  lo_q    <= 1'b0;
                  lcd_d_q <= colour_q[15:8];
                end else begin
                  state_q <= S_PARAM;
                  pcnt_q  <= 2'd0;
                  lcd_d_q <= param_d;
                end
              end

              S_PARAM: begin
                if (pcnt_q == 2'd3) begin
                  state_q <= S_CMD;
                  grp_q   <= grp_q + 2'd1;
                  dcx_q   <= 1'b0;
                  lcd_d_q <= (grp_q == 2'd0) ? CMD_PASET : CMD_RAMWR;
                end else begin
                  pcnt_q  <= pcnt_q + 2'd1;
                  lcd_d_q <= param_d;
                end
              end

              default: begin
                if (!lo_q) begin
                  lo_q    <= 1'b1;
                  lcd_d_q <= colour_q[7:0];
                end else if (pix_q == PIX_LAST) begin
                  // Last strobe already rose; release the bus and signal completion.
                  state_q    <= S_DONE;
                  cmd_done_q <= 1'b1;
                  wrx_q      <= 1'b1;
                  csx_q      <= 1'b1;
                end else begin
                  pix_q   <= pix_q + 1'b1;
                  lo_q    <= 1'b0;
                  lcd_d_q <= colour_q[15:8];
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_done = cmd_done_q;
  assign busy     = busy_q;
  assign lcd_d    = lcd_d_q;
  assign lcd_dcx  = dcx_q;
  assign lcd_wrx  = wrx_q;
  assign lcd_csx  = csx_q;

endmodule

// File: tb/tb_lcd_cell_painter.sv
// Scoreboard bench for lcd_cell_painter: expected bytes queued per request, checked on each wrx rising edge.
module tb_lcd_cell_painter;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en_update;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic [7:0] lcd_d;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic       lcd_csx;

  lcd_cell_painter dut (
    .clk      (clk),
    .nrst     (nrst),
    .en_update(en_update),
    .x        (x),
    .y        (y),
    .obj_code (obj_code),
    .cmd_done (cmd_done),
    .busy     (busy),
    .lcd_d    (lcd_d),
    .lcd_dcx  (lcd_dcx),
    .lcd_wrx  (lcd_wrx),
    .lcd_csx  (lcd_csx)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned edges    = 0;
  int unsigned wr_edges = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  int unsigned req_p    = 0;
  int unsigned wr_base  = 0;
  bit          mon_en   = 1'b0;
  bit          wrx_prev = 1'b1;
  bit          done_prev = 1'b0;
  bit          csx_low_seen = 1'b0;
  logic [8:0]  sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    logic [8:0]  exp_b;
    int unsigned idx;
    if (mon_en) begin
      if (!lcd_csx) csx_low_seen = 1'b1;
      if (!wrx_prev && lcd_wrx) begin
        wr_edges++;
        idx = wr_edges - wr_base - 1;
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_b = sb_q.pop_front();
          check("byte", {23'd0, lcd_dcx, lcd_d}, {23'd0, exp_b});
          check("byte_timing", edges, req_p + 2 * idx + 2);
          check("csx_during_write", 32'(lcd_csx), 32'd0);
        end
      end
      if (cmd_done) begin
        done_cnt++;
        check("done_time", edges, exp_done);
        check("done_consec", 32'(done_prev), 32'd0);
        check("busy_at_done", 32'(busy), 32'd1);
        check("csx_at_done", 32'(lcd_csx), 32'd1);
        check("wrx_at_done", 32'(lcd_wrx), 32'd1);
      end
    end
    wrx_prev  = lcd_wrx;
    done_prev = cmd_done;
  end

  function automatic logic [15:0] model_colour(input logic [2:0] o);
    case (o)
      3'b001:  return 16'h07E0;
      3'b010:  return 16'h03E0;
      3'b011:  return 16'hF800;
      3'b100:  return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_stream(input logic [3:0] xx, input logic [3:0] yy, input logic [2:0] oo);
    logic [15:0] c, x0, x1, y0, y1;
    c  = model_colour(oo);
    x0 = 16'(int'(xx) * 20);
    x1 = x0 + 16'd19;
    y0 = 16'(int'(yy) * 20);
    y1 = y0 + 16'd19;
    sb_q.push_back({1'b0, 8'h2A});
    sb_q.push_back({1'b1, x0[15:8]}); sb_q.push_back({1'b1, x0[7:0]});
    sb_q.push_back({1'b1, x1[15:8]}); sb_q.push_back({1'b1, x1[7:0]});
    sb_q.push_back({1'b0, 8'h2B});
    sb_q.push_back({1'b1, y0[15:8]}); sb_q.push_back({1'b1, y0[7:0]});
    sb_q.push_back({1'b1, y1[15:8]}); sb_q.push_back({1'b1, y1[7:0]});
    sb_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < 400; i++) begin
      sb_q.push_back({1'b1, c[15:8]});
      sb_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic start_req(input logic [3:0] xx, input logic [3:0] yy, input logic [2:0] oo,
                           input bit valid);
    @(negedge clk);
    x = xx; y = yy; obj_code = oo; en_update = 1'b1;
    req_p        = edges;
    wr_base      = wr_edges;
    exp_done     = edges + (valid ? 32'd1623 : 32'd2);
    csx_low_seen = 1'b0;
    if (valid) push_stream(xx, yy, oo);
  endtask

  task automatic request(input logic [3:0] xx, input logic [3:0] yy, input logic [2:0] oo,
                         input bit valid, input bit scramble);
    int unsigned base_done;
    bit          seen;
    base_done = done_cnt;
    start_req(xx, yy, oo, valid);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (scramble) begin
      repeat (40) @(negedge clk);
      x = ~xx; y = 4'd3; obj_code = 3'b011;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base_done) seen = 1'b1;
    end
    check("done_count", done_cnt, base_done + 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("write_count", wr_edges - wr_base, valid ? 32'd811 : 32'd0);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    if (!valid) check("csx_never_low", 32'(csx_low_seen), 32'd0);
  endtask

  task automatic drop_req();
    @(negedge clk);
    en_update = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned hold_wr, hold_done;
    nrst = 1'b0; en_update = 1'b0; x = '0; y = '0; obj_code = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_done", 32'(cmd_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lcd_d", 32'(lcd_d), 32'd0);
    check("rst_dcx", 32'(lcd_dcx), 32'd1);
    check("rst_wrx", 32'(lcd_wrx), 32'd1);
    check("rst_csx", 32'(lcd_csx), 32'd1);
    nrst = 1'b1;
    wrx_prev = lcd_wrx;
    mon_en = 1'b1;

    // Asynchronous reset in the middle of the pixel stream
    start_req(4'd2, 4'd3, 3'b011, 1'b1);
    repeat (100) @(negedge clk);
    check("pre_reset_csx", 32'(lcd_csx), 32'd0);
    #2;
    mon_en = 1'b0;
    nrst = 1'b0;
    #1;
    check("async_csx", 32'(lcd_csx), 32'd1);
    check("async_wrx", 32'(lcd_wrx), 32'd1);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(cmd_done), 32'd0);
    en_update = 1'b0;
    sb_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    wrx_prev = lcd_wrx;
    mon_en = 1'b1;
    @(negedge clk);

    request(4'd4, 4'd4, 3'b001, 1'b1, 1'b0);
    drop_req();
    request(4'd15, 4'd11, 3'b100, 1'b1, 1'b0);
    drop_req();
    request(4'd5, 4'd12, 3'b010, 1'b0, 1'b0);
    drop_req();

    request(4'd1, 4'd2, 3'b011, 1'b1, 1'b0);
    hold_wr   = wr_edges;
    hold_done = done_cnt;
    repeat (50) @(negedge clk);
    check("hold_no_write", wr_edges, hold_wr);
    check("hold_no_done", done_cnt, hold_done);
    check("hold_busy", 32'(busy), 32'd0);
    drop_req();

    request(4'd7, 4'd0, 3'b110, 1'b1, 1'b1);
    drop_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
